// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide sequencer owning the HI/LO registers.
// Staged multiplier plus radix-2 restoring divider, driven by one FSM.
module muldiv_unit #(
  parameter int MUL_STAGES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic        r_done;
  logic [31:0] r_hi, r_lo;

  logic [31:0] r_mul_a, r_mul_b;
  logic        r_mul_sgn;
  logic [31:0] r_dvs, r_rem, r_quo;
  logic        r_sign_q, r_sign_r, r_skip;

  logic               w_issue, w_fin, w_div_sgn, w_ge;
  logic signed [63:0] w_mul_a, w_mul_b, w_prod;
  logic        [32:0] w_rem_sh;
  logic        [31:0] w_rem_nxt;

  function automatic logic [31:0] f_cneg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Operands are extended according to MULT/MULTU so one signed multiply serves both
  assign w_mul_a = {{32{r_mul_sgn & r_mul_a[31]}}, r_mul_a};
  assign w_mul_b = {{32{r_mul_sgn & r_mul_b[31]}}, r_mul_b};
  assign w_prod  = w_mul_a * w_mul_b;

  // Shifted partial remainder needs 33 bits since the divisor may use all 32
  assign w_rem_sh  = {r_rem, r_quo[31]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? 32'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[31:0];
  assign w_div_sgn = (op == OP_DIV);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          case (op)
            OP_MULT, OP_MULTU: w_state_nxt = S_MUL;
            OP_DIV, OP_DIVU:   w_state_nxt = (b == 32'd0) ? S_FIX : S_DIV;
            default:           w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_MUL:   if (r_cnt == 5'd0) w_state_nxt = S_IDLE;
      S_DIV:   if (r_cnt == 5'd0) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_comb begin
    busy    = (r_state != S_IDLE);
    w_issue = (r_state == S_IDLE) && valid && !flush;
    w_fin   = !flush && (((r_state == S_MUL) && (r_cnt == 5'd0)) || (r_state == S_FIX));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt  <= 5'd0;
      r_done <= 1'b0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
    end else begin
      r_done <= w_fin;
      if (w_issue) begin
        case (op)
          OP_MTHI:           r_hi  <= a;
          OP_MTLO:           r_lo  <= a;
          OP_MULT, OP_MULTU: r_cnt <= 5'(MUL_STAGES - 1);
          OP_DIV, OP_DIVU:   r_cnt <= 5'd31;
          default:           ;
        endcase
      end else if (!flush) begin
        case (r_state)
          S_MUL: begin
            if (r_cnt == 5'd0) {r_hi, r_lo} <= w_prod;
            else               r_cnt <= r_cnt - 5'd1;
          end
          S_DIV: if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
          S_FIX: begin
            if (!r_skip) begin
              r_lo <= f_cneg(r_quo, r_sign_q);
              r_hi <= f_cneg(r_rem, r_sign_r);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Operand/partial-result registers carry no reset; they are loaded on issue
  always_ff @(posedge clk) begin
    if (w_issue && ((op == OP_MULT) || (op == OP_MULTU))) begin
      r_mul_a   <= a;
      r_mul_b   <= b;
      r_mul_sgn <= (op == OP_MULT);
    end else if (w_issue && ((op == OP_DIV) || (op == OP_DIVU))) begin
      r_quo    <= f_cneg(a, w_div_sgn & a[31]);
      r_dvs    <= f_cneg(b, w_div_sgn & b[31]);
      r_sign_q <= w_div_sgn & (a[31] ^ b[31]);
      r_sign_r <= w_div_sgn & a[31];
      r_rem    <= 32'd0;
      r_skip   <= (b == 32'd0);
    end else if (r_state == S_DIV) begin
      r_rem <= w_rem_nxt;
      r_quo <= {r_quo[30:0], w_ge};
    end
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for MULT/DIV results and
// hand-written sequences for MT*, divide-by-zero, flush, reset and issue timing.
module tb_muldiv_unit;

  localparam int MS = 1;

  logic        clk = 1'b0;
  logic        resetn, valid, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.MUL_STAGES(MS)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          nb;
  } vec_t;

  vec_t v[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one op and count busy cycles and done pulses until it retires
  task automatic run_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        output int nb, output int nd);
    @(negedge clk); valid = 1'b1; op = o; a = xa; b = xb;
    @(negedge clk); valid = 1'b0; op = 3'd0;
    nb = 0; nd = 0;
    if (done) nd++;
    while (busy && nb < 100) begin
      nb++;
      @(negedge clk);
      if (done) nd++;
    end
    if (nb >= 100) begin
      errors++; checks++;
      $display("FAIL timeout op=%0d: busy cycles %0d required < 100", o, nb);
    end
    @(negedge clk);
    if (done) nd++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int nb, nd;
    v[0] = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, MS};
    v[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MS};
    v[2] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    v[3] = '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14,       33};
    v[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    v[5] = '{3'd1, 32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, MS};
    v[6] = '{3'd4, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, 33};
    v[7] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    v[8] = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MS};

    resetn = 1'b0; valid = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, nb, nd);
      chk($sformatf("vec%0d hi", i), hi, v[i].hi);
      chk($sformatf("vec%0d lo", i), lo, v[i].lo);
      chk($sformatf("vec%0d busy cycles", i), 32'(nb), 32'(v[i].nb));
      chk($sformatf("vec%0d done pulses", i), 32'(nd), 32'd1);
    end

    // MTHI then MTLO back to back
    @(negedge clk); valid = 1'b1; op = 3'd5; a = 32'h1234;
    @(negedge clk); op = 3'd6; a = 32'h5678;
    chk("mthi busy", 32'(busy), 32'd0);
    @(negedge clk); valid = 1'b0; op = 3'd0;
    chk("mtlo busy", 32'(busy), 32'd0);
    chk("mt done", 32'(done), 32'd0);
    chk("mthi hi", hi, 32'h1234);
    chk("mtlo lo", lo, 32'h5678);

    // Divide by zero leaves HI/LO alone
    run_op(3'd5, 32'hAA, 32'd0, nb, nd);
    run_op(3'd6, 32'hBB, 32'd0, nb, nd);
    run_op(3'd4, 32'd5, 32'd0, nb, nd);
    chk("div0 busy cycles", 32'(nb), 32'd1);
    chk("div0 done pulses", 32'(nd), 32'd1);
    chk("div0 hi", hi, 32'hAA);
    chk("div0 lo", lo, 32'hBB);

    // Flush on the 10th busy cycle of a DIVU
    @(negedge clk); valid = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
    @(negedge clk); valid = 1'b0; op = 3'd0;
    repeat (9) @(negedge clk);
    chk("flush pre busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    chk("flush hi", hi, 32'hAA);
    chk("flush lo", lo, 32'hBB);
    @(negedge clk);
    chk("flush done later", 32'(done), 32'd0);

    // Same abort via reset
    @(negedge clk); valid = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
    @(negedge clk); valid = 1'b0; op = 3'd0;
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);

    // MULT held on valid during DIVU: ignored while busy, taken in the done cycle
    @(negedge clk); valid = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
    @(negedge clk); op = 3'd1; a = 32'd3; b = 32'd5;
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    chk("held div busy cycles", 32'(nb), 32'd33);
    chk("held div done", 32'(done), 32'd1);
    chk("held div hi", hi, 32'd2);
    chk("held div lo", lo, 32'd14);
    @(negedge clk); valid = 1'b0; op = 3'd0;
    chk("held mul busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("held mul done", 32'(done), 32'd1);
    chk("held mul busy end", 32'(busy), 32'd0);
    chk("held mul hi", hi, 32'd0);
    chk("held mul lo", lo, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
